// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the normalize/round datapath.
// Both precisions are listed here; the datapath blocks default to single precision.
package fp_pkg;

    // Single precision.
    localparam int SP_MAN_LEN     = 23;
    localparam int SP_EXP_LEN     = 8;
    localparam int SP_BUF_MAN_LEN = 50;
    localparam int SP_BUF_EXP_LEN = 10;
    localparam int SP_BIAS        = 127;

    // Double precision.
    localparam int DP_MAN_LEN     = 52;
    localparam int DP_EXP_LEN     = 11;
    localparam int DP_BUF_MAN_LEN = 108;
    localparam int DP_BUF_EXP_LEN = 13;
    localparam int DP_BIAS        = 1023;

    // Smallest normal unbiased exponent.
    localparam int EMIN    = 1 - SP_BIAS;
    localparam int DP_EMIN = 1 - DP_BIAS;

    // Status flags handed from the normalizer to fp_roundoff.
    typedef struct packed {
        logic sZero;
        logic sSubnormal;
        logic sOverflow;
    } fp_status_t;

endpackage

// File: rtl/fp_normalize_if.sv
// Beat-level bus of the normalizer: raw beat in, normalized beat out.
// The upstream/bench side uses master; the normalizer uses slave.
interface fp_normalize_if
    import fp_pkg::*;
#(
    parameter int BUF_MAN_LEN = SP_BUF_MAN_LEN,
    parameter int BUF_EXP_LEN = SP_BUF_EXP_LEN
);
    logic                          inValid;
    logic                          inReady;
    logic                          rawSign;
    logic        [BUF_MAN_LEN+1:0] rawMan;
    logic signed [BUF_EXP_LEN-1:0] rawExp;
    logic                          outValid;
    logic                          outReady;
    logic                          fSign;
    logic        [BUF_MAN_LEN:0]   fMan;
    logic signed [BUF_EXP_LEN-1:0] fExp;
    logic                          sZero;
    logic                          sSubnormal;
    logic                          sOverflow;

    modport master (
        output inValid, rawSign, rawMan, rawExp, outReady,
        input  inReady, outValid, fSign, fMan, fExp, sZero, sSubnormal, sOverflow
    );

    modport slave (
        input  inValid, rawSign, rawMan, rawExp, outReady,
        output inReady, outValid, fSign, fMan, fExp, sZero, sSubnormal, sOverflow
    );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero vector.
module fp_lzc #(
    parameter  int WIDTH = 51,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CW-1:0]    zeros
);

    // Scan upward so the highest set bit is the last one to update the count.
    always_comb begin
        zeros = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            zeros = vec[i] ? CW'(WIDTH - 1 - i) : zeros;
        end
    end

endmodule

// File: rtl/fp_normalize.sv
// Three-stage normalizer between the add/sub/mul datapath and fp_roundoff:
// S1 registers the beat with its leading-zero count, S2 picks shift and exponent, S3 shifts.
module fp_normalize
    import fp_pkg::*;
#(
    parameter int MAN_LEN     = SP_MAN_LEN,
    parameter int EXP_LEN     = SP_EXP_LEN,
    parameter int BUF_MAN_LEN = SP_BUF_MAN_LEN,
    parameter int BUF_EXP_LEN = SP_BUF_EXP_LEN,
    parameter int BIAS        = SP_BIAS
) (
    input logic           clk,
    input logic           rst,
    fp_normalize_if.slave bus
);

    localparam int MW  = BUF_MAN_LEN + 2;
    localparam int FW  = BUF_MAN_LEN + 1;
    localparam int LZW = $clog2(BUF_MAN_LEN + 2);
    localparam int SHW = $clog2(BUF_MAN_LEN + 3);
    localparam int XW  = BUF_EXP_LEN + 1;

    localparam logic signed [XW-1:0] EMIN_X   = XW'(1 - BIAS);
    localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
    localparam logic signed [XW-1:0] SAT_HI_X = XW'((1 << (BUF_EXP_LEN - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_LO_X = XW'(-(1 << (BUF_EXP_LEN - 1)));
    localparam logic signed [XW-1:0] RCAP_X   = XW'(BUF_MAN_LEN + 2);
    localparam logic        [SHW-1:0] RCAP    = SHW'(BUF_MAN_LEN + 2);

    // The buffer must hold a full product plus guard bits and some exponent headroom.
    if (BUF_MAN_LEN < MAN_LEN + 2 || BUF_EXP_LEN < EXP_LEN + 2) begin : g_bad_cfg
        $error("fp_normalize: buffer widths too small for the stored format");
    end

    logic                          alive_r;
    logic                          v1_r, v2_r, v3_r;
    logic                          en1_s, en2_s, en3_s;
    logic                          sign1_r, sign2_r, fsign_r;
    logic        [MW-1:0]          man1_r, man2_r;
    logic signed [BUF_EXP_LEN-1:0] exp1_r, exp2_r, fexp_r;
    logic        [LZW-1:0]         lzc_s, lzc1_r;
    logic                          zero1_r;
    logic                          right_s, right2_r;
    logic        [SHW-1:0]         amt_s, amt2_r;
    logic signed [XW-1:0]          exp_x_s, lzc_x_s, gap_s, under_s, enew_s;
    logic signed [BUF_EXP_LEN-1:0] esat_s;
    logic                          zero_s, sub_s, ovf_s;
    fp_status_t                    st_s, st2_r, st3_r;
    logic        [FW-1:0]          rsh_s, lsh_s, fman_s, fman_r;
    logic        [MW-1:0]          mask_s;
    logic                          sticky_s;

    // Each stage advances when empty or when the stage after it advances.
    assign en3_s       = ~v3_r | bus.outReady;
    assign en2_s       = ~v2_r | en3_s;
    assign en1_s       = ~v1_r | en2_s;
    assign bus.inReady = alive_r & en1_s;

    fp_lzc #(.WIDTH(BUF_MAN_LEN + 1)) u_lzc (
        .vec   (bus.rawMan[BUF_MAN_LEN:0]),
        .zeros (lzc_s)
    );

    // Holds inReady low until the first clock after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alive_r <= 1'b0;
        else     alive_r <= 1'b1;
    end

    // S1: capture the raw beat with its leading-zero count and zero flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            sign1_r <= 1'b0;
            man1_r  <= {MW{1'b0}};
            exp1_r  <= {BUF_EXP_LEN{1'b0}};
            lzc1_r  <= {LZW{1'b0}};
            zero1_r <= 1'b0;
        end else if (en1_s) begin
            v1_r    <= bus.inValid & bus.inReady;
            sign1_r <= bus.rawSign;
            man1_r  <= bus.rawMan;
            exp1_r  <= bus.rawExp;
            lzc1_r  <= lzc_s;
            zero1_r <= (bus.rawMan == {MW{1'b0}});
        end
    end

    // S2 decision: zero, carry-out, underflow right shift, or bounded left shift.
    always_comb begin
        exp_x_s = {exp1_r[BUF_EXP_LEN-1], exp1_r};
        lzc_x_s = XW'(lzc1_r);
        gap_s   = exp_x_s - EMIN_X;
        under_s = EMIN_X - exp_x_s;
        right_s = 1'b0;
        amt_s   = {SHW{1'b0}};
        enew_s  = exp_x_s;
        zero_s  = 1'b0;
        sub_s   = 1'b0;
        if (zero1_r) begin
            enew_s = {XW{1'b0}};
            zero_s = 1'b1;
        end else if (man1_r[MW-1]) begin
            right_s = 1'b1;
            amt_s   = SHW'(1);
            enew_s  = exp_x_s + XW'(1);
        end else if (exp_x_s < EMIN_X) begin
            right_s = 1'b1;
            amt_s   = (under_s > RCAP_X) ? RCAP : under_s[SHW-1:0];
            enew_s  = EMIN_X;
            sub_s   = 1'b1;
        end else begin
            if (lzc_x_s > gap_s) begin
                amt_s = gap_s[SHW-1:0];
                sub_s = 1'b1;
            end else begin
                amt_s = SHW'(lzc1_r);
            end
            enew_s = exp_x_s - XW'(amt_s);
        end

        if (enew_s > SAT_HI_X) begin
            esat_s = SAT_HI_X[BUF_EXP_LEN-1:0];
        end else if (enew_s < SAT_LO_X) begin
            esat_s = SAT_LO_X[BUF_EXP_LEN-1:0];
        end else begin
            esat_s = enew_s[BUF_EXP_LEN-1:0];
        end

        ovf_s           = ~zero_s & (enew_s > BIAS_X);
        st_s.sZero      = zero_s;
        st_s.sOverflow  = ovf_s;
        st_s.sSubnormal = sub_s & ~ovf_s;
    end

    // S2 register: shift command, final exponent and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r     <= 1'b0;
            sign2_r  <= 1'b0;
            man2_r   <= {MW{1'b0}};
            exp2_r   <= {BUF_EXP_LEN{1'b0}};
            right2_r <= 1'b0;
            amt2_r   <= {SHW{1'b0}};
            st2_r    <= '{1'b0, 1'b0, 1'b0};
        end else if (en2_s) begin
            v2_r     <= v1_r;
            sign2_r  <= sign1_r;
            man2_r   <= man1_r;
            exp2_r   <= esat_s;
            right2_r <= right_s;
            amt2_r   <= amt_s;
            st2_r    <= st_s;
        end
    end

    // S3 barrel shift; bits lost on a right shift fold into the sticky LSB.
    always_comb begin
        rsh_s    = FW'(man2_r >> amt2_r);
        lsh_s    = FW'(man2_r << amt2_r);
        mask_s   = ~({MW{1'b1}} << amt2_r);
        sticky_s = |(man2_r & mask_s);
        if (right2_r) begin
            fman_s = {rsh_s[FW-1:1], rsh_s[0] | sticky_s};
        end else begin
            fman_s = lsh_s;
        end
    end

    // S3 register drives the outputs directly and holds them under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_r    <= 1'b0;
            fsign_r <= 1'b0;
            fman_r  <= {FW{1'b0}};
            fexp_r  <= {BUF_EXP_LEN{1'b0}};
            st3_r   <= '{1'b0, 1'b0, 1'b0};
        end else if (en3_s) begin
            v3_r    <= v2_r;
            fsign_r <= sign2_r;
            fman_r  <= fman_s;
            fexp_r  <= exp2_r;
            st3_r   <= st2_r;
        end
    end

    assign bus.outValid   = v3_r;
    assign bus.fSign      = fsign_r;
    assign bus.fMan       = fman_r;
    assign bus.fExp       = fexp_r;
    assign bus.sZero      = st3_r.sZero;
    assign bus.sSubnormal = st3_r.sSubnormal;
    assign bus.sOverflow  = st3_r.sOverflow;

endmodule

// File: doc/fp_normalize.md
Name: fp_normalize

Overview:
Pipelined post-arithmetic normalizer. It sits directly upstream of fp_roundoff and feeds its fMan/fExp inputs. It takes the raw, unnormalized mantissa and signed unbiased exponent from the add/sub/mul datapath and produces a buffered mantissa with the hidden bit at fMan[BUF_MAN_LEN]. Carry-out, cancellation, zero and subnormal cases are resolved here, so the rounder only handles rounding carry.

Parameters:
MAN_LEN, 23, stored mantissa width (52 for double)
EXP_LEN, 8, stored exponent width (11 for double)
BUF_MAN_LEN, 50, MSB index of buffered mantissa; fMan width is BUF_MAN_LEN+1
BUF_EXP_LEN, 10, signed internal exponent width
BIAS, 127, exponent bias; EMIN = 1-BIAS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inValid  in  1  input beat valid
inReady  out  1  block can accept a beat
rawSign  in  1  result sign
rawMan  in  BUF_MAN_LEN+2  unsigned raw mantissa; bit BUF_MAN_LEN+1 is the carry-out position
rawExp  in  BUF_EXP_LEN  signed unbiased exponent, aligned with bit BUF_MAN_LEN
outValid  out  1  output beat valid
outReady  in  1  downstream accepts
fSign  out  1  sign passthrough
fMan  out  BUF_MAN_LEN+1  normalized/denormalized mantissa, sticky folded into bit 0
fExp  out  BUF_EXP_LEN  signed unbiased exponent
sZero  out  1  result is zero
sSubnormal  out  1  result is in the subnormal range
sOverflow  out  1  fExp > BIAS after normalization

Behaviour:
- Three register stages (S1, S2, S3). Latency is 3 cycles from input handshake to outValid. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers on inValid&inReady and on outValid&outReady.
  - Stage k loads when it is empty or stage k+1 loads (S3 advances on outReady). Bubbles collapse.
  - inReady = ~S1.valid | S1 advances. No combinational path from inValid to inReady.
  - A stalled stage holds its data and valid. Output data stays stable while outValid&~outReady.
- S1: register the inputs. Compute carry = rawMan[BUF_MAN_LEN+1]. Compute lzc = leading zeros of rawMan[BUF_MAN_LEN:0] using sub-module fp_lzc; lzc = BUF_MAN_LEN+1 when all bits are zero. Compute isZero = (rawMan == 0).
- S2: decide the shift direction, shift amount and new exponent, in this priority order:
  - isZero: no shift. fExp=0, sZero=1.
  - carry: right shift by 1, exp = rawExp+1.
  - rawExp < EMIN: right shift by d = EMIN-rawExp, capped at BUF_MAN_LEN+2. exp = EMIN, subnormal=1.
  - otherwise, left shift by s = min(lzc, rawExp-EMIN), exp = rawExp-s. subnormal = (lzc > rawExp-EMIN).
  - The exponent is computed in BUF_EXP_LEN+1 bits and then saturated to BUF_EXP_LEN signed.
  - sOverflow = (exp > BIAS). sOverflow, sZero and sSubnormal are mutually exclusive; sOverflow wins over sSubnormal, which cannot co-occur anyway.
- S3: barrel shift of the registered (BUF_MAN_LEN+2)-bit mantissa.
  - On a right shift, all bits shifted out of the window are ORed into fMan[0] (sticky).
  - On a left shift, zeros fill in from the bottom.
  - The output window is bits [BUF_MAN_LEN:0] after the shift.
- Reset values:
  - All valid bits are 0; inReady goes to 1 on the first cycle after reset deassertion.
  - outValid, fSign, fMan, fExp and all flags are 0.
- Reset asserted mid-stream discards all in-flight beats immediately; no partial output is produced.

Decomposition:
- Shared package fp_pkg holds:
  - precision localparams (MAN_LEN, EXP_LEN, BUF_MAN_LEN, BUF_EXP_LEN, BIAS per precision);
  - the EMIN constant;
  - typedef fp_status_t {sZero, sSubnormal, sOverflow}, also consumed by fp_roundoff.
- One sub-module, fp_lzc: combinational, parameter WIDTH, output width $clog2(WIDTH+1). It is instantiated in S1.

Test Plan:
- rawMan=1<<50, rawExp=0, outReady=1 -> 3 cycles later: fMan=1<<50, fExp=0, all flags 0.
- rawMan=(1<<51)|1, rawExp=5 -> fMan=(1<<50)|1 (sticky), fExp=6.
- rawMan=1<<40, rawExp=3 -> fMan=1<<50, fExp=-7; rawMan=0 -> sZero=1, fMan=0, fExp=0.
- Subnormal path:
  - rawMan=1<<50, rawExp=-130 -> fMan=1<<46, fExp=-126, sSubnormal=1.
  - rawMan=1<<45, rawExp=-124 -> fMan=1<<47, fExp=-126, sSubnormal=1.
- rawMan=1<<51, rawExp=127 -> fExp=128, sOverflow=1.
- Backpressure:
  - Stimulus: 5 back-to-back beats with outReady=0.
  - Expected: exactly 3 accepted, then inReady=0, and output held stable.
  - On release of outReady: all beats emerge in order with no loss or duplication.
  - Assert rst mid-stream: outValid=0 the same cycle, and the pipeline is empty afterwards.
